// File: rtl/bram_dp_if.sv
// Request/acknowledge bus for both ports of bram_dp plus the shared collision flag.
// The memory side uses the slave modport; the requesting side uses master.
interface bram_dp_if #(
    parameter int unsigned data_width = 32
);
    localparam int unsigned nb = data_width / 8;

    logic                  a_stb;
    logic                  a_we;
    logic [nb-1:0]         a_sel;
    logic [15:0]           a_adr;
    logic [data_width-1:0] a_di;
    logic [data_width-1:0] a_do;
    logic                  a_ack;

    logic                  b_stb;
    logic                  b_we;
    logic [nb-1:0]         b_sel;
    logic [15:0]           b_adr;
    logic [data_width-1:0] b_di;
    logic [data_width-1:0] b_do;
    logic                  b_ack;

    logic                  collision;

    modport master (
        output a_stb, a_we, a_sel, a_adr, a_di,
        input  a_do, a_ack,
        output b_stb, b_we, b_sel, b_adr, b_di,
        input  b_do, b_ack,
        input  collision
    );

    modport slave (
        input  a_stb, a_we, a_sel, a_adr, a_di,
        output a_do, a_ack,
        input  b_stb, b_we, b_sel, b_adr, b_di,
        output b_do, b_ack,
        output collision
    );
endinterface

// File: rtl/bram_dp.sv
// True dual-port block RAM with byte enables, port-A write priority, selectable
// read-during-write policy and an optional output register stage.
module bram_dp #(
  parameter string       init_file  = "none",
  parameter int unsigned adr_width  = 11,
  parameter int unsigned data_width = 32,
  parameter int unsigned out_reg    = 0,
  parameter int unsigned rdw_mode   = 0
) (
  input  logic     sys_clk,
  input  logic     sys_rst,
  bram_dp_if.slave bus
);
  localparam int unsigned nb    = data_width / 8;
  localparam int unsigned ob    = $clog2(nb);
  localparam int unsigned aw    = adr_width - ob;
  localparam int unsigned depth = 1 << aw;

  logic [data_width-1:0] mem [depth];

  logic                  a_acc, b_acc;
  logic                  a_wr, b_wr;
  logic                  same_word;
  logic [aw-1:0]         a_idx, b_idx;
  logic [nb-1:0]         a_wen, b_wen;
  logic                  unused_adr_bits;

  logic                  a_v1_d, a_v1_q, b_v1_d, b_v1_q;
  logic [data_width-1:0] a_ram_q, b_ram_q;
  logic [nb-1:0]         a_byp_msk_d, a_byp_msk_q, b_byp_msk_d, b_byp_msk_q;
  logic [data_width-1:0] a_byp_dat_d, a_byp_dat_q, b_byp_dat_d, b_byp_dat_q;
  logic [data_width-1:0] a_rd1, b_rd1;
  logic                  collision_d, collision_q;

  // Decode and write arbitration: B loses any byte that A also writes in the same word.
  always_comb begin
    a_acc           = bus.a_stb & ~sys_rst;
    b_acc           = bus.b_stb & ~sys_rst;
    a_wr            = a_acc & bus.a_we;
    b_wr            = b_acc & bus.b_we;
    a_idx           = bus.a_adr[adr_width-1:ob];
    b_idx           = bus.b_adr[adr_width-1:ob];
    same_word       = (a_idx == b_idx);
    a_wen           = a_wr ? bus.a_sel : '0;
    b_wen           = b_wr ? bus.b_sel : '0;
    collision_d     = same_word & |(a_wen & b_wen);
    if (same_word) b_wen = b_wen & ~a_wen;
    unused_adr_bits = ^{bus.a_adr, bus.b_adr};
  end

  always_ff @(posedge sys_clk) begin
    for (int unsigned i = 0; i < nb; i++) begin
      if (a_wen[i]) mem[a_idx][8*i +: 8] <= bus.a_di[8*i +: 8];
      if (b_wen[i]) mem[b_idx][8*i +: 8] <= bus.b_di[8*i +: 8];
    end
  end

  // Synchronous read ports always capture the pre-write word.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      a_ram_q <= '0;
      b_ram_q <= '0;
    end else begin
      if (a_acc) a_ram_q <= mem[a_idx];
      if (b_acc) b_ram_q <= mem[b_idx];
    end
  end

  // Write-first is built from the read-first RAM plus a registered byte bypass.
  always_comb begin
    a_v1_d      = a_acc;
    b_v1_d      = b_acc;
    a_byp_msk_d = a_byp_msk_q;
    a_byp_dat_d = a_byp_dat_q;
    b_byp_msk_d = b_byp_msk_q;
    b_byp_dat_d = b_byp_dat_q;
    if (a_acc) begin
      a_byp_msk_d = '0;
      a_byp_dat_d = '0;
      if (rdw_mode != 0) begin
        a_byp_msk_d = a_wen | (same_word ? b_wen : '0);
        for (int unsigned i = 0; i < nb; i++)
          a_byp_dat_d[8*i +: 8] = a_wen[i] ? bus.a_di[8*i +: 8] : bus.b_di[8*i +: 8];
      end
    end
    if (b_acc) begin
      b_byp_msk_d = '0;
      b_byp_dat_d = '0;
      if (rdw_mode != 0) begin
        b_byp_msk_d = b_wen | (same_word ? a_wen : '0);
        for (int unsigned i = 0; i < nb; i++)
          b_byp_dat_d[8*i +: 8] = (same_word && a_wen[i]) ? bus.a_di[8*i +: 8]
                                                          : bus.b_di[8*i +: 8];
      end
    end
  end

  always_comb begin
    a_rd1 = '0;
    b_rd1 = '0;
    for (int unsigned i = 0; i < nb; i++) begin
      a_rd1[8*i +: 8] = a_byp_msk_q[i] ? a_byp_dat_q[8*i +: 8] : a_ram_q[8*i +: 8];
      b_rd1[8*i +: 8] = b_byp_msk_q[i] ? b_byp_dat_q[8*i +: 8] : b_ram_q[8*i +: 8];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      a_v1_q      <= 1'b0;
      b_v1_q      <= 1'b0;
      a_byp_msk_q <= '0;
      a_byp_dat_q <= '0;
      b_byp_msk_q <= '0;
      b_byp_dat_q <= '0;
      collision_q <= 1'b0;
    end else begin
      a_v1_q      <= a_v1_d;
      b_v1_q      <= b_v1_d;
      a_byp_msk_q <= a_byp_msk_d;
      a_byp_dat_q <= a_byp_dat_d;
      b_byp_msk_q <= b_byp_msk_d;
      b_byp_dat_q <= b_byp_dat_d;
      collision_q <= collision_d;
    end
  end

  // Outputs are masked during reset so acks already in the pipeline are dropped that cycle.
  assign bus.collision = collision_q & ~sys_rst;

  if (out_reg != 0) begin : g_oreg
    logic                  a_v2_d, a_v2_q, b_v2_d, b_v2_q;
    logic [data_width-1:0] a_out_d, a_out_q, b_out_d, b_out_q;

    always_comb begin
      a_v2_d  = a_v1_q;
      b_v2_d  = b_v1_q;
      a_out_d = a_v1_q ? a_rd1 : a_out_q;
      b_out_d = b_v1_q ? b_rd1 : b_out_q;
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        a_v2_q  <= 1'b0;
        b_v2_q  <= 1'b0;
        a_out_q <= '0;
        b_out_q <= '0;
      end else begin
        a_v2_q  <= a_v2_d;
        b_v2_q  <= b_v2_d;
        a_out_q <= a_out_d;
        b_out_q <= b_out_d;
      end
    end

    assign bus.a_ack = a_v2_q & ~sys_rst;
    assign bus.b_ack = b_v2_q & ~sys_rst;
    assign bus.a_do  = sys_rst ? '0 : a_out_q;
    assign bus.b_do  = sys_rst ? '0 : b_out_q;
  end else begin : g_noreg
    assign bus.a_ack = a_v1_q & ~sys_rst;
    assign bus.b_ack = b_v1_q & ~sys_rst;
    assign bus.a_do  = sys_rst ? '0 : a_rd1;
    assign bus.b_do  = sys_rst ? '0 : b_rd1;
  end
endmodule

// File: tb/tb_bram_dp.sv
// Drives two bram_dp instances (latency 1 / read-first and latency 2 / write-first)
// with one shared stimulus and compares both against a cycle-level memory model.
module tb_bram_dp;
    localparam int DEPTH = 512;

    logic        clk;
    logic        rst;
    logic        a_stb, a_we, b_stb, b_we;
    logic [3:0]  a_sel, b_sel;
    logic [15:0] a_adr, b_adr;
    logic [31:0] a_di, b_di;

    int cyc;
    int checks;
    int passes;

    bram_dp_if #(.data_width(32)) ifc0 ();
    bram_dp_if #(.data_width(32)) ifc1 ();

    assign ifc0.a_stb = a_stb;  assign ifc1.a_stb = a_stb;
    assign ifc0.a_we  = a_we;   assign ifc1.a_we  = a_we;
    assign ifc0.a_sel = a_sel;  assign ifc1.a_sel = a_sel;
    assign ifc0.a_adr = a_adr;  assign ifc1.a_adr = a_adr;
    assign ifc0.a_di  = a_di;   assign ifc1.a_di  = a_di;
    assign ifc0.b_stb = b_stb;  assign ifc1.b_stb = b_stb;
    assign ifc0.b_we  = b_we;   assign ifc1.b_we  = b_we;
    assign ifc0.b_sel = b_sel;  assign ifc1.b_sel = b_sel;
    assign ifc0.b_adr = b_adr;  assign ifc1.b_adr = b_adr;
    assign ifc0.b_di  = b_di;   assign ifc1.b_di  = b_di;

    bram_dp #(.init_file("none"), .adr_width(11), .data_width(32), .out_reg(0), .rdw_mode(0)) dut0 (
        .sys_clk(clk), .sys_rst(rst), .bus(ifc0)
    );
    bram_dp #(.init_file("none"), .adr_width(11), .data_width(32), .out_reg(1), .rdw_mode(1)) dut1 (
        .sys_clk(clk), .sys_rst(rst), .bus(ifc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word array plus expected responses indexed by due cycle.
    logic [31:0] mdl [DEPTH];
    bit          pend_v [2][2][4];
    logic [31:0] pend_d [2][2][4];
    logic [31:0] hold   [2][2];
    int          col_due;

    function automatic logic [31:0] put(input logic [31:0] w, input logic [31:0] di, input logic [3:0] sel);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 4; i++)
            if (sel[i]) r[8*i +: 8] = di[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    endtask

    task automatic clear_model_pipe();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                hold[d][p] = '0;
                for (int s = 0; s < 4; s++) pend_v[d][p][s] = 1'b0;
            end
        col_due = -1;
    endtask

    task automatic check_outputs();
        logic [31:0] obs_do  [2][2];
        logic        obs_ack [2][2];
        logic        obs_col [2];
        logic        exp_ack;
        int          slot;
        obs_do[0][0] = ifc0.a_do;   obs_ack[0][0] = ifc0.a_ack;
        obs_do[0][1] = ifc0.b_do;   obs_ack[0][1] = ifc0.b_ack;
        obs_do[1][0] = ifc1.a_do;   obs_ack[1][0] = ifc1.a_ack;
        obs_do[1][1] = ifc1.b_do;   obs_ack[1][1] = ifc1.b_ack;
        obs_col[0]   = ifc0.collision;
        obs_col[1]   = ifc1.collision;
        slot = cyc % 4;
        if (rst) clear_model_pipe();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                exp_ack = !rst && pend_v[d][p][slot];
                if (exp_ack) hold[d][p] = pend_d[d][p][slot];
                pend_v[d][p][slot] = 1'b0;
                chk($sformatf("dut%0d_%s_ack", d, p ? "b" : "a"), {31'b0, obs_ack[d][p]}, {31'b0, exp_ack});
                chk($sformatf("dut%0d_%s_do", d, p ? "b" : "a"), obs_do[d][p], hold[d][p]);
            end
            chk($sformatf("dut%0d_collision", d), {31'b0, obs_col[d]}, {31'b0, (!rst && col_due == cyc)});
        end
    endtask

    task automatic model_step();
        int          ai, bi, slot;
        logic [31:0] old_a, old_b, new_a, new_b;
        if (rst) return;
        ai    = (int'(a_adr) >> 2) % DEPTH;
        bi    = (int'(b_adr) >> 2) % DEPTH;
        old_a = mdl[ai];
        old_b = mdl[bi];
        if (b_stb && b_we) mdl[bi] = put(mdl[bi], b_di, b_sel);
        if (a_stb && a_we) mdl[ai] = put(mdl[ai], a_di, a_sel);
        new_a = mdl[ai];
        new_b = mdl[bi];
        for (int d = 0; d < 2; d++) begin
            slot = (cyc + d + 1) % 4;
            if (a_stb) begin pend_v[d][0][slot] = 1'b1; pend_d[d][0][slot] = d ? new_a : old_a; end
            if (b_stb) begin pend_v[d][1][slot] = 1'b1; pend_d[d][1][slot] = d ? new_b : old_b; end
        end
        if (a_stb && a_we && b_stb && b_we && ai == bi && (a_sel & b_sel) != 4'b0)
            col_due = cyc + 1;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        a_stb = 1'b0; a_we = 1'b0; a_sel = '0; a_adr = '0; a_di = '0;
        b_stb = 1'b0; b_we = 1'b0; b_sel = '0; b_adr = '0; b_di = '0;
    endtask

    task automatic req_a(input logic we, input logic [15:0] adr, input logic [3:0] sel, input logic [31:0] di);
        a_stb = 1'b1; a_we = we; a_adr = adr; a_sel = sel; a_di = di;
    endtask

    task automatic req_b(input logic we, input logic [15:0] adr, input logic [3:0] sel, input logic [31:0] di);
        b_stb = 1'b1; b_we = we; b_adr = adr; b_sel = sel; b_di = di;
    endtask

    function automatic logic [15:0] rand_adr();
        logic [15:0] r;
        if ($urandom_range(0, 1) == 0)
            r = 16'(($urandom_range(0, 3) << 2) | ($urandom & 3) | (($urandom & 31) << 11));
        else
            r = 16'($urandom);
        return r;
    endfunction

    initial begin
        cyc    = 0;
        checks = 0;
        passes = 0;
        clear_model_pipe();
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;

        // Reset state.
        repeat (3) tick();
        rst = 1'b0;

        // Fill every word through both ports.
        for (int w = 0; w < DEPTH / 2; w++) begin
            req_a(1'b1, 16'(w * 8),     4'hF, $urandom);
            req_b(1'b1, 16'(w * 8 + 4), 4'hF, $urandom);
            tick();
        end
        idle();
        tick();

        // Byte-enable write then cross-port read.
        req_a(1'b1, 16'h000C, 4'hF, 32'h11223344); tick();
        req_a(1'b1, 16'h000C, 4'b0101, 32'hAABBCCDD); tick();
        idle(); req_b(1'b0, 16'h000C, 4'h0, 32'h0); tick();
        idle(); tick();
        chk("byte_write_dut0", ifc0.b_do, 32'h11BB33DD);
        chk("byte_write_dut1", ifc1.b_do, 32'h11BB33DD);
        tick();

        // Same-word write/write collision, A wins overlapping byte 1.
        req_a(1'b1, 16'h001C, 4'hF, 32'hFFFFFFFF); tick();
        req_a(1'b1, 16'h001C, 4'b0011, 32'h000000A1);
        req_b(1'b1, 16'h001C, 4'b0110, 32'h0000B200); tick();
        chk("collision_dut0", {31'b0, ifc0.collision}, 32'h1);
        chk("collision_dut1", {31'b0, ifc1.collision}, 32'h1);
        idle(); req_a(1'b0, 16'h001C, 4'h0, 32'h0); tick();
        idle(); tick();
        chk("collision_word_dut0", ifc0.a_do, 32'hFF0000A1);
        chk("collision_word_dut1", ifc1.a_do, 32'hFF0000A1);
        tick();

        // Read-during-write on the same port and across ports.
        req_a(1'b1, 16'h0008, 4'hF, 32'h1); tick();
        req_a(1'b1, 16'h0008, 4'hF, 32'h2);
        req_b(1'b0, 16'h0008, 4'h0, 32'h0); tick();
        idle(); tick();
        chk("rdw_cross_dut0", ifc0.b_do, 32'h1);
        chk("rdw_cross_dut1", ifc1.b_do, 32'h2);
        chk("rdw_same_dut0", ifc0.a_do, 32'h1);
        chk("rdw_same_dut1", ifc1.a_do, 32'h2);
        tick();

        // Back-to-back reads fill the pipeline without gaps.
        for (int w = 0; w < 4; w++) begin
            req_a(1'b0, 16'(w * 4), 4'h0, 32'h0);
            tick();
        end
        idle();
        repeat (3) tick();

        // Reset mid-operation: in-flight read dropped, write during reset ignored.
        req_a(1'b0, 16'h0010, 4'h0, 32'h0); tick();
        idle(); rst = 1'b1; req_b(1'b1, 16'h0024, 4'hF, 32'hCAFEF00D); tick();
        rst = 1'b0; idle(); tick();
        req_b(1'b0, 16'h0024, 4'h0, 32'h0); tick();
        idle(); repeat (2) tick();

        // Address wrap modulo depth.
        req_a(1'b0, 16'h0804, 4'h0, 32'h0); tick();
        idle(); tick();
        chk("wrap_dut0", ifc0.a_do, mdl[1]);
        tick();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            idle();
            if ($urandom_range(0, 3) != 0) req_a($urandom_range(0, 1) == 1, rand_adr(), 4'($urandom), $urandom);
            if ($urandom_range(0, 3) != 0) req_b($urandom_range(0, 1) == 1, rand_adr(), 4'($urandom), $urandom);
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (4) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
